// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern in the flopped bit stream, then
// shifts in WIDTH data bits MSB-first and optionally checks a trailing even-parity bit.
module serial_frame_rx #(
   parameter int unsigned         WIDTH     = 8,
   parameter int unsigned         SYNC_LEN  = 4,
   parameter logic [SYNC_LEN-1:0] SYNC      = 4'b1011,
   parameter bit                  PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             parity_err,
   output logic             busy
);

   localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
   localparam int unsigned HCNT_W = $clog2(SYNC_LEN + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [HCNT_W-1:0] HUNT_MIN = HCNT_W'(SYNC_LEN - 1);
   localparam logic [HCNT_W-1:0] HUNT_MAX = HCNT_W'(SYNC_LEN);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [SYNC_LEN-1:0] window_q, window_d;
   logic [HCNT_W-1:0]   hcnt_q,   hcnt_d;
   logic [WIDTH-1:0]    shreg_q,  shreg_d;
   logic [CNT_W-1:0]    bcnt_q,   bcnt_d;
   logic [WIDTH-1:0]    data_q,   data_d;
   logic                perr_q,   perr_d;
   logic                valid_q,  valid_d;
   logic                busy_q,   busy_d;

   logic [SYNC_LEN-1:0] window_shift;

   // NOTE: every variable gets its hold value before the case so no path leaves
   // one unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d      = state_q;
      window_d     = window_q;
      hcnt_d       = hcnt_q;
      shreg_d      = shreg_q;
      bcnt_d       = bcnt_q;
      data_d       = data_q;
      perr_d       = perr_q;
      valid_d      = 1'b0;
      window_shift = {window_q[SYNC_LEN-2:0], d};

      if (en) begin
         unique case (state_q)
            HUNT: begin
               window_d = window_shift;
               if (hcnt_q != HUNT_MAX) begin
                  hcnt_d = hcnt_q + HCNT_W'(1);
               end
               // Requiring SYNC_LEN-1 prior bits stops stale zeros in the cleared window matching.
               if ((hcnt_q >= HUNT_MIN) && (window_shift == SYNC)) begin
                  state_d  = DATA;
                  bcnt_d   = '0;
                  window_d = '0;
                  hcnt_d   = '0;
               end
            end
            DATA: begin
               shreg_d = {shreg_q[WIDTH-2:0], d};
               bcnt_d  = bcnt_q + CNT_W'(1);
               if (bcnt_q == LAST_BIT) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                  end else begin
                     data_d  = shreg_d;
                     perr_d  = 1'b0;
                     valid_d = 1'b1;
                     state_d = HUNT;
                  end
               end
            end
            PARITY: begin
               data_d  = shreg_q;
               perr_d  = d ^ (^shreg_q);
               valid_d = 1'b1;
               state_d = HUNT;
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end

      busy_d = (state_d != HUNT);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would let order of statements change behaviour.
   // NOTE: the shift register is small and reset explicitly, so a mid-frame reset
   // leaves no residue of the aborted frame anywhere in the datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         window_q <= '0;
         hcnt_q   <= '0;
         shreg_q  <= '0;
         bcnt_q   <= '0;
         data_q   <= '0;
         perr_q   <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         hcnt_q   <= hcnt_d;
         shreg_q  <= shreg_d;
         bcnt_q   <= bcnt_d;
         data_q   <= data_d;
         perr_q   <= perr_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: drivers push hand-computed frames, monitors
// pop and compare on every valid strobe of the 8-bit/parity and 4-bit/no-parity instances.
module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       d   = 1'b0;
   logic       en4 = 1'b0;
   logic       d4  = 1'b0;

   logic [7:0] data_out;
   logic       valid, parity_err, busy;
   logic [3:0] data_out4;
   logic       valid4, parity_err4, busy4;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   int checks      = 0;
   int failures    = 0;
   int busy_total  = 0;
   int valid_total = 0;
   logic prev_valid  = 1'b0;
   logic prev_valid4 = 1'b0;

   always #5 clk = ~clk;

   serial_frame_rx dut8 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .d          (d),
      .data_out   (data_out),
      .valid      (valid),
      .parity_err (parity_err),
      .busy       (busy)
   );

   serial_frame_rx #(
      .WIDTH     (4),
      .PARITY_EN (1'b0)
   ) dut4 (
      .clk        (clk),
      .rst        (rst),
      .en         (en4),
      .d          (d4),
      .data_out   (data_out4),
      .valid      (valid4),
      .parity_err (parity_err4),
      .busy       (busy4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors sample on the falling edge, half a cycle after outputs settle.
   always @(negedge clk) begin
      exp_t e;
      if (busy) busy_total++;
      if (valid) begin
         valid_total++;
         check("sb8_valid_prev_cycle", {31'b0, prev_valid}, 32'd0);
         check("sb8_expect_pending", {31'b0, q8.size() > 0}, 32'd1);
         if (q8.size() > 0) begin
            e = q8.pop_front();
            check("sb8_data_out", {24'b0, data_out}, {24'b0, e.data});
            check("sb8_parity_err", {31'b0, parity_err}, {31'b0, e.perr});
         end
      end
      prev_valid = valid;

      if (valid4) begin
         check("sb4_valid_prev_cycle", {31'b0, prev_valid4}, 32'd0);
         check("sb4_expect_pending", {31'b0, q4.size() > 0}, 32'd1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            check("sb4_data_out", {28'b0, data_out4}, {24'b0, e.data});
            check("sb4_parity_err", {31'b0, parity_err4}, {31'b0, e.perr});
         end
      end
      prev_valid4 = valid4;
   end

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         en = 1'b0;
         d  = 1'($urandom_range(0, 1));
      end
   endtask

   // Sends n bits MSB-first; with gaps=1, three en=0 cycles follow every second bit.
   task automatic send_seq(input logic [31:0] bits, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         en = 1'b1;
         d  = bits[i];
         if (gaps && ((n - 1 - i) % 2 == 1) && (i != 0)) gap(3);
      end
   endtask

   // Checks valid appears exactly one cycle after the final bit and lasts one cycle,
   // with en held high on the following edge.
   task automatic finish_frame8();
      @(negedge clk);
      en = 1'b1;
      d  = 1'b0;
      check("valid_latency", {31'b0, valid}, 32'd1);
      @(negedge clk);
      en = 1'b0;
      check("valid_one_cycle", {31'b0, valid}, 32'd0);
   endtask

   task automatic send_frame8(input logic [31:0] bits, input int n, input bit gaps,
                              input logic [7:0] exp_data, input logic exp_perr);
      q8.push_back('{data: exp_data, perr: exp_perr});
      send_seq(bits, n, gaps);
      finish_frame8();
   endtask

   initial begin
      int b0;
      int v0;

      // Reset state
      @(negedge clk);
      check("rst_data_out", {24'b0, data_out}, 32'd0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_parity_err", {31'b0, parity_err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst4_data_out", {28'b0, data_out4}, 32'd0);
      rst = 1'b0;
      gap(2);

      // 1: basic frame, busy for exactly 9 cycles
      b0 = busy_total;
      v0 = valid_total;
      send_frame8({19'b0, 4'b1011, 8'hA5, 1'b0}, 13, 1'b0, 8'hA5, 1'b0);
      check("t1_busy_cycles", 32'(busy_total - b0), 32'd9);
      check("t1_valid_count", 32'(valid_total - v0), 32'd1);
      gap(3);

      // 2: parity error still delivers the word; next clean frame clears the flag
      send_frame8({19'b0, 4'b1011, 8'hA5, 1'b1}, 13, 1'b0, 8'hA5, 1'b1);
      gap(2);
      b0 = busy_total;
      send_frame8({19'b0, 4'b1011, 8'h3C, 1'b0}, 13, 1'b0, 8'h3C, 1'b0);
      check("t2_busy_cycles", 32'(busy_total - b0), 32'd9);
      gap(2);

      // 3: overlapping sync (1,0,1,0,1,1) and a data byte containing the sync pattern
      v0 = valid_total;
      send_frame8({17'b0, 6'b101011, 8'hFF, 1'b0}, 15, 1'b0, 8'hFF, 1'b0);
      gap(2);
      send_frame8({19'b0, 4'b1011, 8'hB0, 1'b1}, 13, 1'b0, 8'hB0, 1'b0);
      gap(4);
      check("t3_valid_count", 32'(valid_total - v0), 32'd2);

      // 4: en gaps with random d
      v0 = valid_total;
      send_frame8({19'b0, 4'b1011, 8'hA5, 1'b0}, 13, 1'b1, 8'hA5, 1'b0);
      gap(4);
      check("t4_valid_count", 32'(valid_total - v0), 32'd1);

      // 5: reset after four data bits aborts the frame and clears data_out
      send_seq({24'b0, 4'b1011, 4'b1010}, 8, 1'b0);
      @(negedge clk);
      en = 1'b0;
      check("t5_busy_before_rst", {31'b0, busy}, 32'd1);
      check("t5_data_held", {24'b0, data_out}, 32'h0000_00A5);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", {31'b0, valid}, 32'd0);
      check("t5_rst_busy", {31'b0, busy}, 32'd0);
      check("t5_rst_data_out", {24'b0, data_out}, 32'd0);
      check("t5_rst_parity_err", {31'b0, parity_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      gap(1);
      send_frame8({19'b0, 4'b1011, 8'h5A, 1'b0}, 13, 1'b0, 8'h5A, 1'b0);
      gap(2);

      // 6: WIDTH=4, no parity bit
      q4.push_back('{data: 8'h0C, perr: 1'b0});
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] bits4;
         bits4 = 8'b1011_1100;
         @(negedge clk);
         en4 = 1'b1;
         d4  = bits4[i];
      end
      @(negedge clk);
      en4 = 1'b0;
      check("t6_valid_latency", {31'b0, valid4}, 32'd1);
      check("t6_busy_drop", {31'b0, busy4}, 32'd0);
      @(negedge clk);
      check("t6_valid_one_cycle", {31'b0, valid4}, 32'd0);
      check("t6_data_held", {28'b0, data_out4}, 32'h0000_000C);

      // Bounded drain of both scoreboards
      for (int i = 0; i < 10; i++) begin
         if (q8.size() == 0 && q4.size() == 0) break;
         @(negedge clk);
      end
      check("sb8_drained", 32'(q8.size()), 32'd0);
      check("sb4_drained", 32'(q4.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
